// File: rtl/dispatch_wide_pkg.sv
// rtl/dispatch_wide_pkg.sv - ooop_types: rename packet, RS entry and FU type shared by the dispatch slice
package ooop_types;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_LSU = 2'd2
  } fu_type_t;

  typedef struct packed {
    fu_type_t    fu_type;
    logic [3:0]  op;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [15:0] imm;
  } rename_pkt_t;

  typedef struct packed {
    logic        valid;
    fu_type_t    fu_type;
    logic [3:0]  op;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic [15:0] imm;
  } rs_entry_t;

  function automatic rs_entry_t to_rs_entry(rename_pkt_t p);
    rs_entry_t e;
    e.valid   = 1'b1;
    e.fu_type = p.fu_type;
    e.op      = p.op;
    e.prd     = p.prd;
    e.prs1    = p.prs1;
    e.prs2    = p.prs2;
    e.imm     = p.imm;
    return e;
  endfunction

  function automatic logic [31:0] sat_inc32(logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/dispatch_wide_if.sv
// rtl/dispatch_wide_if.sv - rename input, RS insert and ROB allocate signals of the wide dispatch stage
interface dispatch_wide_if
  import ooop_types::*;
#(
  parameter int DISP_W    = 2,
  parameter int ROB_CNT_W = 4
);
  localparam int DCW = $clog2(DISP_W + 1);

  logic                     valid_in;
  logic                     ready_out;
  rename_pkt_t              pkt_in;
  logic                     rs_alu_ready_i;
  logic                     rs_bru_ready_i;
  logic                     rs_lsu_ready_i;
  logic                     rs_alu_valid_o;
  logic                     rs_bru_valid_o;
  logic                     rs_lsu_valid_o;
  rs_entry_t                rs_alu_entry_o;
  rs_entry_t                rs_bru_entry_o;
  rs_entry_t                rs_lsu_entry_o;
  logic [ROB_CNT_W-1:0]     rob_free_i;
  logic [DISP_W-1:0]        rob_alloc_valid_o;
  rename_pkt_t [DISP_W-1:0] rob_alloc_pkt_o;
  logic [DCW-1:0]           disp_count_o;

  modport master (
    output valid_in, pkt_in, rs_alu_ready_i, rs_bru_ready_i, rs_lsu_ready_i, rob_free_i,
    input  ready_out, rs_alu_valid_o, rs_bru_valid_o, rs_lsu_valid_o,
           rs_alu_entry_o, rs_bru_entry_o, rs_lsu_entry_o,
           rob_alloc_valid_o, rob_alloc_pkt_o, disp_count_o
  );

  modport slave (
    input  valid_in, pkt_in, rs_alu_ready_i, rs_bru_ready_i, rs_lsu_ready_i, rob_free_i,
    output ready_out, rs_alu_valid_o, rs_bru_valid_o, rs_lsu_valid_o,
           rs_alu_entry_o, rs_bru_entry_o, rs_lsu_entry_o,
           rob_alloc_valid_o, rob_alloc_pkt_o, disp_count_o
  );

endinterface

// File: rtl/dispatch_wide_queue.sv
// rtl/dispatch_wide_queue.sv - dispatch_queue: circular packet buffer, single push, multi-pop, flush clear
module dispatch_queue
  import ooop_types::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DISP_W = 2,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int DCW    = $clog2(DISP_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  rename_pkt_t              push_pkt,
  input  logic [DCW-1:0]           pop_cnt,
  output logic [CW-1:0]            count,
  output rename_pkt_t [DISP_W-1:0] head_pkt
);

  rename_pkt_t    mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;

  // DEPTH is a power of two, so PW-bit pointer arithmetic wraps on its own
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      head_pkt[k] = mem[head + PW'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_pkt;
        tail      <= tail + PW'(1);
      end
      head  <= head + PW'(pop_cnt);
      count <= count + CW'(push) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/dispatch_wide.sv
// rtl/dispatch_wide.sv - dispatch_wide: in-order multi-lane dispatch into ALU/BRU/LSU RS with ROB lanes
// Optional stall/empty statistics counters are built when DISPATCH_STATS_EN is defined.
module dispatch_wide
  import ooop_types::*;
#(
  parameter int DEPTH     = 4,
  parameter int DISP_W    = 2,
  parameter int ROB_CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]    stall_rob_o,
  output logic [31:0]    stall_rs_o,
  output logic [31:0]    empty_o,
`endif
  dispatch_wide_if.slave bus
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DCW = $clog2(DISP_W + 1);

  logic [CW-1:0]            count;
  rename_pkt_t [DISP_W-1:0] slot;
  logic [DCW-1:0]           disp_cnt;
  logic                     push;
  logic [ROB_CNT_W-1:0]     rob_free;
  logic [3:0]               rs_ready;
  logic [3:0]               used;
  logic                     fire_prev;
  logic                     fire_k;
  fu_type_t                 fu;

  assign rob_free      = bus.rob_free_i;
  assign bus.ready_out = (count < CW'(DEPTH));
  assign push          = bus.valid_in && bus.ready_out && !flush_i;

  // Indexed by fu_type; the unused encoding has no ready bit, so it can never fire.
  assign rs_ready = {1'b0, bus.rs_lsu_ready_i, bus.rs_bru_ready_i, bus.rs_alu_ready_i};

  dispatch_queue #(
    .DEPTH  (DEPTH),
    .DISP_W (DISP_W)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_i),
    .push     (push),
    .push_pkt (bus.pkt_in),
    .pop_cnt  (disp_cnt),
    .count    (count),
    .head_pkt (slot)
  );

  always_comb begin
    fire_prev             = 1'b1;
    fire_k                = 1'b0;
    fu                    = FU_ALU;
    used                  = '0;
    disp_cnt              = '0;
    bus.rs_alu_valid_o    = 1'b0;
    bus.rs_bru_valid_o    = 1'b0;
    bus.rs_lsu_valid_o    = 1'b0;
    bus.rs_alu_entry_o    = '0;
    bus.rs_bru_entry_o    = '0;
    bus.rs_lsu_entry_o    = '0;
    bus.rob_alloc_valid_o = '0;
    for (int k = 0; k < DISP_W; k++) begin
      fu     = slot[k].fu_type;
      fire_k = fire_prev && (int'(count) > k) && (int'(rob_free) > k) && !flush_i
               && rs_ready[fu] && !used[fu];
      if (fire_k) begin
        used[fu]                 = 1'b1;
        bus.rob_alloc_valid_o[k] = 1'b1;
        disp_cnt                 = disp_cnt + DCW'(1);
        case (fu)
          FU_ALU: begin
            bus.rs_alu_valid_o = 1'b1;
            bus.rs_alu_entry_o = to_rs_entry(slot[k]);
          end
          FU_BRU: begin
            bus.rs_bru_valid_o = 1'b1;
            bus.rs_bru_entry_o = to_rs_entry(slot[k]);
          end
          default: begin
            bus.rs_lsu_valid_o = 1'b1;
            bus.rs_lsu_entry_o = to_rs_entry(slot[k]);
          end
        endcase
      end
      fire_prev = fire_k;
    end
  end

  assign bus.rob_alloc_pkt_o = slot;
  assign bus.disp_count_o    = disp_cnt;

`ifdef DISPATCH_STATS_EN
  // Attribute each non-flush cycle to at most one reason lane 0 did not make progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_o <= '0;
      stall_rs_o  <= '0;
      empty_o     <= '0;
    end else if (!flush_i) begin
      if (count == '0) begin
        empty_o <= sat_inc32(empty_o);
      end else if (rob_free == '0) begin
        stall_rob_o <= sat_inc32(stall_rob_o);
      end else if (!rs_ready[slot[0].fu_type]) begin
        stall_rs_o <= sat_inc32(stall_rs_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_wide.sv
// tb/tb_dispatch_wide.sv - randomized self-checking bench for dispatch_wide against a queue-based model
module tb_dispatch_wide;
  import ooop_types::*;

  localparam int DEPTH     = 4;
  localparam int DISP_W    = 2;
  localparam int ROB_CNT_W = 4;
  localparam int DCW       = $clog2(DISP_W + 1);
  localparam int EW        = $bits(rs_entry_t);
  localparam int PKW       = $bits(rename_pkt_t);
  localparam int VW        = 1 + DCW + 3 + 3 * EW + DISP_W + DISP_W * PKW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;

  dispatch_wide_if #(.DISP_W(DISP_W), .ROB_CNT_W(ROB_CNT_W)) bus ();

`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_rob_o, stall_rs_o, empty_o;
`endif

  dispatch_wide #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ROB_CNT_W(ROB_CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
`ifdef DISPATCH_STATS_EN
    .stall_rob_o (stall_rob_o),
    .stall_rs_o  (stall_rs_o),
    .empty_o     (empty_o),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  rename_pkt_t    mq[$];
  int             n_checks = 0;
  int             n_pass   = 0;
  int             exp_disp = 0;
  int             live     = 0;
  int             m_empty  = 0;
  int             m_rob    = 0;
  int             m_rs     = 0;
  logic [VW-1:0]  exp_vec;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && mq.size() > 0)
      assert (bus.rob_alloc_pkt_o[0].fu_type inside {FU_ALU, FU_BRU, FU_LSU})
        else $error("illegal fu_type at queue head");
  end

  function automatic bit rdy_of(int f);
    case (f)
      0:       return bus.rs_alu_ready_i;
      1:       return bus.rs_bru_ready_i;
      2:       return bus.rs_lsu_ready_i;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rename_pkt_t rand_pkt(fu_type_t fu);
    logic [63:0] r;
    rename_pkt_t p;
    r = {$urandom, $urandom};
    p = r[PKW-1:0];
    p.fu_type = fu;
    return p;
  endfunction

  function automatic logic [VW-1:0] dut_vec(int lv);
    rename_pkt_t [DISP_W-1:0] p;
    p = bus.rob_alloc_pkt_o;
    for (int k = 0; k < DISP_W; k++) if (k >= lv) p[k] = '0;
    return {bus.ready_out, bus.disp_count_o, bus.rs_alu_valid_o, bus.rs_bru_valid_o,
            bus.rs_lsu_valid_o, bus.rs_alu_entry_o, bus.rs_bru_entry_o, bus.rs_lsu_entry_o,
            bus.rob_alloc_valid_o, p};
  endfunction

  // Oldest-first walk over the packet list: take each packet whose unit is free and ready,
  // stop at the first one that cannot go.
  task automatic model_eval();
    logic [2:0] v;
    rs_entry_t e[3];
    logic [DISP_W-1:0] rv;
    rename_pkt_t [DISP_W-1:0] p;
    bit [3:0] taken;
    bit blocked;
    v = '0; rv = '0; p = '0; taken = '0; blocked = 0; exp_disp = 0;
    for (int i = 0; i < 3; i++) e[i] = '0;
    live = (mq.size() < DISP_W) ? mq.size() : DISP_W;
    for (int k = 0; k < live; k++) begin
      int f = int'(mq[k].fu_type);
      p[k] = mq[k];
      if (!blocked && rst_n && !flush_i && int'(bus.rob_free_i) > k && f < 3
          && rdy_of(f) && !taken[f]) begin
        taken[f] = 1'b1;
        v[f] = 1'b1;
        e[f] = '{valid: 1'b1, fu_type: mq[k].fu_type, op: mq[k].op, prd: mq[k].prd,
                 prs1: mq[k].prs1, prs2: mq[k].prs2, imm: mq[k].imm};
        rv[k] = 1'b1;
        exp_disp++;
      end else begin
        blocked = 1;
      end
    end
    exp_vec = {(mq.size() < DEPTH), DCW'(exp_disp), v[0], v[1], v[2], e[0], e[1], e[2], rv, p};
  endtask

  task automatic model_step();
    bit acc;
    if (!rst_n) return;
    acc = bus.valid_in && !flush_i && (mq.size() < DEPTH);
    if (!flush_i) begin
      if (mq.size() == 0) m_empty++;
      else if (bus.rob_free_i == 0) m_rob++;
      else if (!rdy_of(int'(mq[0].fu_type))) m_rs++;
    end
    if (flush_i) mq.delete();
    else begin
      repeat (exp_disp) void'(mq.pop_front());
      if (acc) mq.push_back(bus.pkt_in);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_inputs(bit v, rename_pkt_t p, bit a, bit b, bit l, int rf, bit fl);
    bus.valid_in       = v;
    bus.pkt_in         = p;
    bus.rs_alu_ready_i = a;
    bus.rs_bru_ready_i = b;
    bus.rs_lsu_ready_i = l;
    bus.rob_free_i     = ROB_CNT_W'(rf);
    flush_i            = fl;
  endtask

  task automatic clear_q();
    set_inputs(0, '0, 1, 1, 1, 8, 1);
    settle();
    advance();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mq.delete();
    m_empty = 0; m_rob = 0; m_rs = 0;
    set_inputs(1, rand_pkt(FU_ALU), 1, 1, 1, 8, 0);
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL reset c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
`ifdef DISPATCH_STATS_EN
      n_checks++;
      if ({empty_o, stall_rob_o, stall_rs_o} !== 96'd0)
        $display("FAIL reset_stats: got %h want 0", {empty_o, stall_rob_o, stall_rs_o});
      else n_pass++;
`endif
      advance();
    end
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    settle();
    n_checks++;
    if (dut_vec(live) !== exp_vec) $display("FAIL reset_release: got %h want %h", dut_vec(live), exp_vec);
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    fu_type_t seq[3] = '{FU_ALU, FU_BRU, FU_LSU};
    int tbl[6] = '{0, 1, 1, 1, 0, 0};
    for (int c = 0; c < 6; c++) begin
      set_inputs(c < 3, rand_pkt(seq[c % 3]), 1, 1, 1, 8, 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL b2b c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      n_checks++;
      if (int'(bus.disp_count_o) !== tbl[c]) $display("FAIL b2b_count c%0d: got %0d want %0d", c, bus.disp_count_o, tbl[c]);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_same_rs();
    int tbl[4] = '{1, 1, 1, 0};
    clear_q();
    for (int c = 0; c < 7; c++) begin
      if (c < 3) set_inputs(1, rand_pkt(FU_ALU), 0, 0, 0, 8, 0);
      else       set_inputs(0, '0, 1, 1, 1, 8, 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL same_rs c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      if (c >= 3) begin
        n_checks++;
        if (int'(bus.disp_count_o) !== tbl[c-3]) $display("FAIL same_rs_count c%0d: got %0d want %0d", c, bus.disp_count_o, tbl[c-3]);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_rob_limit();
    int rf[3]  = '{1, 2, 2};
    int tbl[3] = '{1, 1, 0};
    clear_q();
    set_inputs(1, rand_pkt(FU_BRU), 0, 0, 0, 8, 0);
    settle(); advance();
    set_inputs(1, rand_pkt(FU_LSU), 0, 0, 0, 8, 0);
    settle(); advance();
    for (int c = 0; c < 3; c++) begin
      set_inputs(0, '0, 1, 1, 1, rf[c], 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL rob_limit c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      n_checks++;
      if (int'(bus.disp_count_o) !== tbl[c]) $display("FAIL rob_limit_count c%0d: got %0d want %0d", c, bus.disp_count_o, tbl[c]);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_no_bypass();
    fu_type_t seq[4] = '{FU_ALU, FU_LSU, FU_LSU, FU_BRU};
    clear_q();
    for (int c = 0; c < 9; c++) begin
      if (c < 6) set_inputs(1, rand_pkt(seq[c % 4]), 0, 1, 1, 8, 0);
      else       set_inputs(0, '0, 1, 1, 1, 8, 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL no_bypass c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      if (c == 4 || c == 5) begin
        n_checks++;
        if (bus.ready_out !== 1'b0 || bus.rs_lsu_valid_o !== 1'b0)
          $display("FAIL no_bypass_full c%0d: ready_out %b lsu_valid %b want 0 0", c, bus.ready_out, bus.rs_lsu_valid_o);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_flush();
    clear_q();
    for (int c = 0; c < 4; c++) begin
      set_inputs(1, rand_pkt(fu_type_t'(c % 3)), 0, 0, 0, 8, 0);
      settle(); advance();
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_inputs(1, rand_pkt(FU_ALU), 1, 1, 1, 8, 1);
      else        set_inputs(0, '0, 1, 1, 1, 8, 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL flush c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      n_checks++;
      if (bus.disp_count_o !== '0 || bus.rob_alloc_valid_o !== '0 || bus.ready_out !== (c != 0))
        $display("FAIL flush_state c%0d: disp %0d rob_v %b ready %b want 0 0 %b", c,
                 bus.disp_count_o, bus.rob_alloc_valid_o, bus.ready_out, c != 0);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_inputs($urandom_range(0, 1), rand_pkt(fu_type_t'($urandom_range(0, 2))),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 19) == 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL random c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      advance();
    end
`ifdef DISPATCH_STATS_EN
    settle();
    n_checks++;
    if (int'(empty_o) !== m_empty || int'(stall_rob_o) !== m_rob || int'(stall_rs_o) !== m_rs)
      $display("FAIL random_stats: got %0d %0d %0d want %0d %0d %0d",
               empty_o, stall_rob_o, stall_rs_o, m_empty, m_rob, m_rs);
    else n_pass++;
    advance();
`endif
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    mq.delete();
    m_empty = 0; m_rob = 0; m_rs = 0;
    set_inputs(0, '0, 0, 1, 1, 8, 0);
    settle(); advance();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_inputs(c == 2, rand_pkt(FU_ALU), 0, 1, 1, 8, 0);
      settle();
      n_checks++;
      if (dut_vec(live) !== exp_vec) $display("FAIL stats c%0d: got %h want %h", c, dut_vec(live), exp_vec);
      else n_pass++;
      advance();
    end
    settle();
    n_checks++;
    if (empty_o !== 32'd3 || stall_rs_o !== 32'd2 || stall_rob_o !== 32'd0)
      $display("FAIL stats_counts: empty %0d rs %0d rob %0d want 3 2 0", empty_o, stall_rs_o, stall_rob_o);
    else n_pass++;
    advance();
  endtask
`endif

  initial begin
    set_inputs(0, '0, 1, 1, 1, 8, 0);
    test_reset();
    test_back_to_back();
    test_same_rs();
    test_rob_limit();
    test_no_bypass();
    test_flush();
    test_random();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
